// File: rtl/sirius_pkg.sv
// rtl/sirius_pkg.sv - shared fetch-path types and constants
package sirius_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode handshake bundle for fetch_queue
interface fetch_queue_if;

    logic [1:0]  in_valid;
    logic [31:0] in_instr0;
    logic [31:0] in_pc0;
    logic [31:0] in_instr1;
    logic [31:0] in_pc1;
    logic        in_ready;
    logic        out_valid0;
    logic [31:0] out_instr0;
    logic [31:0] out_pc0;
    logic        out_valid1;
    logic [31:0] out_instr1;
    logic [31:0] out_pc1;
    logic [1:0]  out_ack;

    modport master (
        output in_valid, in_instr0, in_pc0, in_instr1, in_pc1, out_ack,
        input  in_ready, out_valid0, out_instr0, out_pc0,
               out_valid1, out_instr1, out_pc1
    );

    modport slave (
        input  in_valid, in_instr0, in_pc0, in_instr1, in_pc1, out_ack,
        output in_ready, out_valid0, out_instr0, out_pc0,
               out_valid1, out_instr1, out_pc1
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - entry storage, two write ports and two async read ports
module fetch_queue_mem
    import sirius_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we0,
    input  logic [AW-1:0] waddr0,
    input  fetch_entry_t wdata0,
    input  logic         we1,
    input  logic [AW-1:0] waddr1,
    input  fetch_entry_t wdata1,
    input  logic [AW-1:0] raddr0,
    output fetch_entry_t rdata0,
    input  logic [AW-1:0] raddr1,
    output fetch_entry_t rdata1
);

    fetch_entry_t mem [DEPTH];

    // Write addresses are always consecutive, so the two ports never collide.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-issue fetch buffer; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue
    import sirius_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    fetch_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head, tail;
    logic          in_ready;
    logic          vin0, vin1, ack0, ack1;
    logic          vis0, vis1, bypass;
    logic [1:0]    n_in, n_pop, n_skip, n_wr, mem_pop;
    fetch_entry_t  in_e0, in_e1, rd0, rd1, e_out0, e_out1, wdata0;

    // An illegal bit1-without-bit0 request behaves as if bit1 were clear.
    assign vin0 = bus.in_valid[0];
    assign vin1 = bus.in_valid[0] & bus.in_valid[1];
    assign ack0 = bus.out_ack[0];
    assign ack1 = bus.out_ack[0] & bus.out_ack[1];

    assign in_ready     = count <= CW'(DEPTH - 2);
    assign bus.in_ready = in_ready;

    assign in_e0 = '{pc: bus.in_pc0, instr: bus.in_instr0};
    assign in_e1 = '{pc: bus.in_pc1, instr: bus.in_instr1};
    assign n_in  = in_ready ? ({1'b0, vin0} + {1'b0, vin1}) : 2'd0;

    always_comb begin
        bypass = 1'b0;
        vis0   = count >= CW'(1);
        vis1   = count >= CW'(2);
        e_out0 = rd0;
        e_out1 = rd1;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (count == '0 && !flush) begin
            bypass = 1'b1;
            vis0   = vin0;
            vis1   = vin1;
            e_out0 = in_e0;
            e_out1 = in_e1;
        end
`endif
        n_pop   = {1'b0, ack0 & vis0} + {1'b0, ack1 & vis1};
        // Bypassed entries consumed this cycle never reach storage.
        n_skip  = bypass ? n_pop : 2'd0;
        mem_pop = bypass ? 2'd0 : n_pop;
        n_wr    = n_in - n_skip;
        wdata0  = (n_skip == 2'd0) ? in_e0 : in_e1;
    end

    assign bus.out_valid0 = vis0;
    assign bus.out_pc0    = vis0 ? e_out0.pc    : 32'h0;
    assign bus.out_instr0 = vis0 ? e_out0.instr : NOP_INSTR;
    assign bus.out_valid1 = vis1;
    assign bus.out_pc1    = vis1 ? e_out1.pc    : 32'h0;
    assign bus.out_instr1 = vis1 ? e_out1.instr : NOP_INSTR;

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .we0    (rst && !flush && n_wr >= 2'd1),
        .waddr0 (tail),
        .wdata0 (wdata0),
        .we1    (rst && !flush && n_wr >= 2'd2),
        .waddr1 (tail + AW'(1)),
        .wdata1 (in_e1),
        .raddr0 (head),
        .rdata0 (rd0),
        .raddr1 (head + AW'(1)),
        .rdata1 (rd1)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(mem_pop);
            tail  <= tail + AW'(n_wr);
            count <= count + CW'(n_wr) - CW'(mem_pop);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (bus.in_valid != 2'b10) else $error("fetch_queue: in_valid=2'b10");
            assert (bus.out_ack != 2'b10) else $error("fetch_queue: out_ack=2'b10");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [4:0] count;
    int         errors = 0;
    int         checks = 0;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [1:0] ack, input logic fl);
        bus.in_valid  = v;
        bus.in_pc0    = pc0;
        bus.in_instr0 = ~pc0;
        bus.in_pc1    = pc1;
        bus.in_instr1 = ~pc1;
        bus.out_ack   = ack;
        flush         = fl;
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(2'b11, 32'h50, 32'h54, 2'b00, 1'b0);
        tick();
        tick();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid0 got=%b exp=0", bus.out_valid0); end
        checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got=%b exp=0", bus.out_valid1); end
        rst = 1'b1;
        idle();
        #1;
        checks++; if (bus.out_instr0 !== 32'h0) begin errors++; $display("FAIL reset_out_instr0 got=%h exp=0", bus.out_instr0); end
    endtask

    task automatic test_dual_push();
        idle();
        bus.in_valid  = 2'b11;
        bus.in_pc0    = 32'h100;
        bus.in_instr0 = 32'h24010001;
        bus.in_pc1    = 32'h104;
        bus.in_instr1 = 32'h24020002;
        tick();
        idle();
        checks++; if (bus.out_pc0 !== 32'h100) begin errors++; $display("FAIL dual_pc0 got=%h exp=100", bus.out_pc0); end
        checks++; if (bus.out_pc1 !== 32'h104) begin errors++; $display("FAIL dual_pc1 got=%h exp=104", bus.out_pc1); end
        checks++; if (bus.out_instr0 !== 32'h24010001) begin errors++; $display("FAIL dual_instr0 got=%h exp=24010001", bus.out_instr0); end
        checks++; if (bus.out_instr1 !== 32'h24020002) begin errors++; $display("FAIL dual_instr1 got=%h exp=24020002", bus.out_instr1); end
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL dual_count got=%0d exp=2", count); end
        bus.out_ack = 2'b01;
        tick();
        checks++; if (bus.out_pc0 !== 32'h104) begin errors++; $display("FAIL pop1_pc0 got=%h exp=104", bus.out_pc0); end
        checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL pop1_valid1 got=%b exp=0", bus.out_valid1); end
        checks++; if (bus.out_instr1 !== 32'h0) begin errors++; $display("FAIL pop1_instr1 got=%h exp=0", bus.out_instr1); end
        tick();
        idle();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL pop2_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill_wrap();
        logic [31:0] exp_q[$];
        logic [31:0] pc;
        int          sz;
        pc = 32'h1000;
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready k=%0d got=%b exp=1", k, bus.in_ready); end
            drive(2'b11, pc, pc + 32'h4, 2'b00, 1'b0);
            exp_q.push_back(pc);
            exp_q.push_back(pc + 32'h4);
            pc += 32'h8;
            tick();
        end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full16_ready got=%b exp=0", bus.in_ready); end
        drive(2'b11, 32'hDEAD0000, 32'hDEAD0004, 2'b01, 1'b0);
        void'(exp_q.pop_front());
        tick();
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL drop_count got=%0d exp=15", count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full15_ready got=%b exp=0", bus.in_ready); end
        drive(2'b11, 32'hDEAD0008, 32'hDEAD000C, 2'b00, 1'b0);
        tick();
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL drop2_count got=%0d exp=15", count); end
        for (int c = 0; c < 14; c++) begin
            sz = exp_q.size();
            checks++; if (count !== 5'(sz)) begin errors++; $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, count, sz); end
            checks++; if (bus.out_pc0 !== exp_q[0]) begin errors++; $display("FAIL wrap_pc0 c=%0d got=%h exp=%h", c, bus.out_pc0, exp_q[0]); end
            checks++; if (bus.out_pc1 !== exp_q[1]) begin errors++; $display("FAIL wrap_pc1 c=%0d got=%h exp=%h", c, bus.out_pc1, exp_q[1]); end
            checks++; if (bus.out_instr0 !== ~exp_q[0]) begin errors++; $display("FAIL wrap_instr0 c=%0d got=%h exp=%h", c, bus.out_instr0, ~exp_q[0]); end
            drive(2'b11, pc, pc + 32'h4, 2'b11, 1'b0);
            if (sz <= 14) begin
                exp_q.push_back(pc);
                exp_q.push_back(pc + 32'h4);
            end
            pc += 32'h8;
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            tick();
        end
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
        tick();
        idle();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_flush_count got=%0d exp=0", count); end
    endtask

    task automatic test_over_ack();
        drive(2'b01, 32'h400, 32'h0, 2'b00, 1'b0);
        tick();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL overack_pre_count got=%0d exp=1", count); end
        drive(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        tick();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL overack_count got=%0d exp=0", count); end
        checks++; if (bus.out_valid0 !== 1'b0) begin errors++; $display("FAIL overack_valid0 got=%b exp=0", bus.out_valid0); end
        drive(2'b01, 32'h404, 32'h0, 2'b00, 1'b0);
        tick();
        idle();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL overack_post_count got=%0d exp=1", count); end
        checks++; if (bus.out_pc0 !== 32'h404) begin errors++; $display("FAIL overack_head got=%h exp=404", bus.out_pc0); end
    endtask

    task automatic test_flush_collision();
        drive(2'b01, 32'h500, 32'h0, 2'b00, 1'b0);
        tick();
        drive(2'b11, 32'h504, 32'h508, 2'b00, 1'b0);
        tick();
        drive(2'b11, 32'h50C, 32'h510, 2'b00, 1'b0);
        tick();
        checks++; if (count !== 5'd6) begin errors++; $display("FAIL flush_pre_count got=%0d exp=6", count); end
        drive(2'b11, 32'h514, 32'h518, 2'b11, 1'b1);
        tick();
        idle();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (bus.out_valid0 !== 1'b0) begin errors++; $display("FAIL flush_valid0 got=%b exp=0", bus.out_valid0); end
        drive(2'b01, 32'h200, 32'h0, 2'b00, 1'b0);
        tick();
        idle();
        checks++; if (bus.out_pc0 !== 32'h200) begin errors++; $display("FAIL flush_refetch_pc0 got=%h exp=200", bus.out_pc0); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL flush_refetch_count got=%0d exp=1", count); end
        flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        drive(2'b11, 32'h300, 32'h304, 2'b01, 1'b0);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++; if (bus.out_valid0 !== 1'b1) begin errors++; $display("FAIL byp_valid0 got=%b exp=1", bus.out_valid0); end
        checks++; if (bus.out_pc0 !== 32'h300) begin errors++; $display("FAIL byp_pc0 got=%h exp=300", bus.out_pc0); end
        tick();
        idle();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL byp_count got=%0d exp=1", count); end
        checks++; if (bus.out_pc0 !== 32'h304) begin errors++; $display("FAIL byp_next_pc0 got=%h exp=304", bus.out_pc0); end
`else
        checks++; if (bus.out_valid0 !== 1'b0) begin errors++; $display("FAIL nobyp_valid0 got=%b exp=0", bus.out_valid0); end
        tick();
        idle();
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL nobyp_count got=%0d exp=2", count); end
        checks++; if (bus.out_pc0 !== 32'h300) begin errors++; $display("FAIL nobyp_next_pc0 got=%h exp=300", bus.out_pc0); end
`endif
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_dual_push();
        test_fill_wrap();
        test_over_ack();
        test_flush_collision();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
